// File: rtl/frac_frame_tx.sv
// Buffers whole fractional snapshots in a frame FIFO and serializes each frame
// as CTR_NUM tagged words {channel, frac} over a valid/ready stream.
module frac_frame_tx #(
  parameter int CTR_NUM    = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int CW = $clog2(CTR_NUM),
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int LW = PW + 1
) (
  input  logic          clock,
  input  logic          rst,
  input  logic [6:0]    in_data [CTR_NUM],
  input  logic          in_valid,
  output logic [CW+6:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sof,
  output logic          out_eof,
  output logic [15:0]   drop_cnt,
  output logic [LW-1:0] fifo_level
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [6:0]    r_mem [FIFO_DEPTH][CTR_NUM];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_ch;
  logic [0:0]    r_state;

  logic          w_full;
  logic          w_push;
  logic          w_xfer;
  logic          w_last;
  logic          w_pop;
  logic [CW-1:0] w_next_ch;

  // Fullness is judged on the registered level, so a same-cycle pop never frees a slot.
  assign w_full    = (fifo_level == LW'(FIFO_DEPTH));
  assign w_push    = in_valid & ~w_full;
  assign w_xfer    = (r_state == S_SEND) & out_ready;
  assign w_last    = (r_ch == CW'(CTR_NUM - 1));
  assign w_pop     = w_xfer & w_last;
  assign w_next_ch = r_ch + CW'(1);

  // Frame storage: a whole snapshot is written into the tail slot.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  // FIFO pointers, occupancy and saturating drop counter.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= PW'(0);
      r_rd_ptr   <= PW'(0);
      fifo_level <= LW'(0);
      drop_cnt   <= 16'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (in_valid && w_full && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  // Serializer FSM; output word is preloaded so it stays stable while stalled.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_ch      <= CW'(0);
      out_valid <= 1'b0;
      out_data  <= (CW + 7)'(0);
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (fifo_level != LW'(0)) begin
            r_state   <= S_SEND;
            r_ch      <= CW'(0);
            out_valid <= 1'b1;
            out_data  <= {CW'(0), r_mem[r_rd_ptr][0]};
            out_sof   <= 1'b1;
            out_eof   <= 1'b0;
          end
        end
        S_SEND: begin
          if (out_ready) begin
            if (w_last) begin
              r_state   <= S_IDLE;
              r_ch      <= CW'(0);
              out_valid <= 1'b0;
              out_data  <= (CW + 7)'(0);
              out_sof   <= 1'b0;
              out_eof   <= 1'b0;
            end else begin
              r_ch      <= w_next_ch;
              out_data  <= {w_next_ch, r_mem[r_rd_ptr][w_next_ch]};
              out_sof   <= 1'b0;
              out_eof   <= (w_next_ch == CW'(CTR_NUM - 1));
            end
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_ch      <= CW'(0);
          out_valid <= 1'b0;
          out_data  <= (CW + 7)'(0);
          out_sof   <= 1'b0;
          out_eof   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frac_frame_tx.sv
// Directed + randomized bench for frac_frame_tx against a frame-queue reference model.
module tb_frac_frame_tx;
  localparam int N  = 8;
  localparam int D  = 4;
  localparam int CW = 3;
  localparam int W  = CW + 7;
  localparam int LW = 3;

  logic          clock = 1'b0;
  logic          rst = 1'b1;
  logic [6:0]    in_data [N];
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_sof;
  logic          out_eof;
  logic [15:0]   drop_cnt;
  logic [LW-1:0] fifo_level;

  int checks = 0;
  int failures = 0;

  // Reference model: queue of expected words plus frame count and drop count.
  logic [W-1:0] q_word[$];
  bit           q_sof[$];
  bit           q_eof[$];
  int           m_level = 0;
  int           m_drop = 0;
  int           words_seen = 0;
  int           pushes_ok = 0;

  frac_frame_tx #(.CTR_NUM(N), .FIFO_DEPTH(D)) dut (
    .clock(clock), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_eof(out_eof), .drop_cnt(drop_cnt), .fifo_level(fifo_level)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_snap();
    for (int c = 0; c < N; c++) in_data[c] = 7'($urandom);
  endtask

  task automatic model_clear();
    q_word.delete();
    q_sof.delete();
    q_eof.delete();
    m_level = 0;
    m_drop = 0;
  endtask

  task automatic push_frame();
    for (int c = 0; c < N; c++) begin
      q_word.push_back({CW'(c), in_data[c]});
      q_sof.push_back(c == 0);
      q_eof.push_back(c == N - 1);
    end
    m_level++;
    pushes_ok++;
  endtask

  // One clock: check visible word, predict push/drop/pop, then check state after the edge.
  task automatic tick();
    logic         hold;
    logic [W+1:0] held;
    hold = out_valid && !out_ready;
    held = {out_sof, out_eof, out_data};
    if (out_valid) begin
      if (q_word.size() == 0) begin
        chk("spurious_valid", 32'(out_valid), 32'd0);
      end else begin
        chk("word", 32'(out_data), 32'(q_word[0]));
        chk("sof", 32'(out_sof), 32'(q_sof[0]));
        chk("eof", 32'(out_eof), 32'(q_eof[0]));
      end
    end
    if (in_valid) begin
      if (m_level < D) push_frame();
      else if (m_drop < 65535) m_drop++;
    end
    if (out_valid && out_ready && q_word.size() > 0) begin
      if (q_eof[0]) m_level--;
      void'(q_word.pop_front());
      void'(q_sof.pop_front());
      void'(q_eof.pop_front());
      words_seen++;
    end
    @(posedge clock);
    #1;
    chk("level", 32'(fifo_level), 32'(m_level));
    chk("drop", 32'(drop_cnt), 32'(m_drop));
    if (hold) chk("stall_hold", 32'({out_valid, out_sof, out_eof, out_data}), 32'({1'b1, held}));
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_sof"}, 32'(out_sof), 32'd0);
    chk({tag, "_eof"}, 32'(out_eof), 32'd0);
    chk({tag, "_data"}, 32'(out_data), 32'd0);
    chk({tag, "_level"}, 32'(fifo_level), 32'd0);
    chk({tag, "_drop"}, 32'(drop_cnt), 32'd0);
  endtask

  // Asynchronous assert, check immediately, hold over an edge, release after it.
  task automatic do_reset(input string tag);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    reset_chk(tag);
    model_clear();
    @(posedge clock);
    #1;
    reset_chk({tag, "_held"});
    rst = 1'b1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while ((q_word.size() != 0 || out_valid) && n < 2000) begin
      tick();
      n++;
    end
    chk({tag, "_drained"}, 32'(q_word.size() == 0 && !out_valid), 32'd1);
  endtask

  task automatic wait_tag(input int tag_v, input string tag);
    int n;
    n = 0;
    while (!(out_valid && out_data[W-1:7] == CW'(tag_v)) && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_reached"}, 32'(out_valid && out_data[W-1:7] == CW'(tag_v)), 32'd1);
  endtask

  initial begin
    int w0;
    int n;
    int p0;
    for (int c = 0; c < N; c++) in_data[c] = 7'd0;
    #2;
    do_reset("reset");

    // Single snapshot, latency and exact word values.
    for (int c = 0; c < N; c++) in_data[c] = 7'(8'h10 + c);
    w0 = words_seen;
    out_ready = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("lat_edge_k_valid", 32'(out_valid), 32'd0);
    tick();
    chk("lat_edge_k1_valid", 32'(out_valid), 32'd1);
    chk("lat_first_word", 32'(out_data), 32'h010);
    chk("lat_first_sof", 32'(out_sof), 32'd1);
    for (int c = 1; c < N; c++) tick();
    chk("single_last_word", 32'(out_data), 32'h397);
    chk("single_last_eof", 32'(out_eof), 32'd1);
    drain("single");
    chk("single_words", 32'(words_seen - w0), 32'd8);

    // Stall at channel 3 for five cycles.
    w0 = words_seen;
    rand_snap();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_tag(3, "stall");
    out_ready = 1'b0;
    repeat (5) tick();
    chk("stall_tag", 32'(out_data[W-1:7]), 32'd3);
    drain("stall");
    chk("stall_words", 32'(words_seen - w0), 32'd8);

    // Overflow: six pulses into a blocked output.
    do_reset("reset_ovf");
    w0 = words_seen;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rand_snap();
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
    end
    chk("ovf_level", 32'(fifo_level), 32'd4);
    chk("ovf_drop", 32'(drop_cnt), 32'd2);
    drain("ovf");
    chk("ovf_words", 32'(words_seen - w0), 32'd32);

    // Push on the eof edge: full -> dropped, level 4->3; level 2 -> queued, stays 2.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rand_snap();
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_tag(N - 1, "sim_full");
    chk("sim_full_level_pre", 32'(fifo_level), 32'd4);
    p0 = m_drop;
    rand_snap();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("sim_full_level", 32'(fifo_level), 32'd3);
    chk("sim_full_drop", 32'(drop_cnt), 32'(p0 + 1));
    n = 0;
    while (!(out_valid && out_eof && fifo_level == LW'(2)) && n < 200) begin
      tick();
      n++;
    end
    chk("sim_l2_reached", 32'(out_valid && out_eof && fifo_level == LW'(2)), 32'd1);
    rand_snap();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("sim_l2_level", 32'(fifo_level), 32'd2);
    chk("sim_l2_drop", 32'(drop_cnt), 32'(p0 + 1));
    drain("sim");

    // Reset mid-frame with two frames queued.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rand_snap();
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_tag(4, "mid");
    do_reset("mid_reset");
    rand_snap();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("post_reset_level", 32'(fifo_level), 32'd1);
    tick();
    chk("post_reset_sof", 32'(out_sof), 32'd1);
    chk("post_reset_tag", 32'(out_data[W-1:7]), 32'd0);
    drain("post_reset");

    // Twenty frames with random ready/valid to exercise pointer wrap.
    w0 = words_seen;
    p0 = pushes_ok;
    n = 0;
    while ((pushes_ok - p0 < 20 || q_word.size() != 0 || out_valid) && n < 5000) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid = (pushes_ok - p0 < 20) && ($urandom_range(0, 2) == 0);
      rand_snap();
      tick();
      n++;
    end
    in_valid = 1'b0;
    chk("wrap_frames", 32'(pushes_ok - p0), 32'd20);
    chk("wrap_words", 32'(words_seen - w0), 32'd160);

    // Saturation of the drop counter.
    out_ready = 1'b0;
    in_valid = 1'b1;
    repeat (70004) tick();
    in_valid = 1'b0;
    chk("drop_saturated", 32'(drop_cnt), 32'hFFFF);
    drain("sat");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
